// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the parametrised sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_AND   = 3'b001,
    ALU_XOR   = 3'b010,
    ALU_SHIFT = 3'b011,
    ALU_MULLO = 3'b100,
    ALU_MULHI = 3'b101,
    ALU_OR    = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_t;

  function automatic int shamt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/control/flag bundle between the register-file side and the ALU.
interface alu_seq_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic [2:0]       i_aluOp;
   logic             i_subShiftDir;
   logic             i_useCarry;
   logic             i_aluWr;
   logic             i_noe;
   logic             o_negative;
   logic             o_nZero;
   logic             o_carry;
   logic             o_overflow;
   logic             o_busy;

   modport slave (
      input  i_a, i_b, i_aluOp, i_subShiftDir, i_useCarry, i_aluWr, i_noe,
      output o_negative, o_nZero, o_carry, o_overflow, o_busy
   );

   modport master (
      output i_a, i_b, i_aluOp, i_subShiftDir, i_useCarry, i_aluWr, i_noe,
      input  o_negative, o_nZero, o_carry, o_overflow, o_busy
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     sum;
   logic [CW-1:0]      cnt;
   logic               busy;

   // acc holds {partial product, remaining multiplier bits}; each step adds
   // the multiplicand into the top half and shifts the pair right by one.
   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_nxt = {sum, acc[WIDTH-1:1]};
   end

   assign o_busy = busy;
   assign o_done = busy && (cnt == CW'(WIDTH - 1));
   assign o_prod = acc_nxt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         busy  <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
      end else if (busy) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (o_done) busy <= 1'b0;
      end else if (i_start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         acc   <= {{WIDTH{1'b0}}, i_b};
         mcand <= i_a;
      end
   end
endmodule

// File: rtl/alu_tx8.sv
// 8-bit bus transmitter cell with active-low output enable.
module alu_tx8 (
   input  logic [7:0] i_d,
   input  logic       i_noe,
   output tri   [7:0] o_q
);
   assign o_q = i_noe ? 8'hzz : i_d;
endmodule

// File: rtl/alu_seq.sv
// Registered-result ALU: add/sub, logic, shift/rotate and optional iterative multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   alu_seq_if.slave         bus,
   output tri   [WIDTH-1:0] o_y
);
   localparam int SW = shamt_w(WIDTH);

   logic [WIDTH-1:0] r_y;
   logic             r_carry;
   logic             r_ovf;
   logic             mul_hi_q;

   logic             mul_busy;
   logic             mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   alu_op_t          op;
   logic             is_mul;
   logic [WIDTH-1:0] bp;
   logic [WIDTH:0]   sum;
   logic             cin;
   logic [SW-1:0]    n, ridx, lidx;
   logic [WIDTH-1:0] res_y;
   logic             res_c;
   logic             res_v;

   assign op     = alu_op_t'(bus.i_aluOp);
   assign is_mul = (op == ALU_MULLO) || (op == ALU_MULHI);

   always_comb begin
      res_y = r_y;
      res_c = r_carry;
      res_v = 1'b0;
      bp    = bus.i_b ^ {WIDTH{bus.i_subShiftDir}};
      cin   = bus.i_useCarry ? r_carry : bus.i_subShiftDir;
      sum   = {1'b0, bus.i_a} + {1'b0, bp} + (WIDTH+1)'(cin);
      n     = bus.i_b[SW-1:0];
      ridx  = n - SW'(1);
      lidx  = SW'(0) - n;
      unique case (op)
         ALU_ADD: begin
            res_y = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (bus.i_a[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != bus.i_a[WIDTH-1]);
         end
         ALU_AND:   res_y = bus.i_a & bus.i_b;
         ALU_XOR:   res_y = bus.i_a ^ bus.i_b;
         ALU_OR:    res_y = bus.i_a | bus.i_b;
         ALU_PASSB: res_y = bus.i_b;
         ALU_SHIFT: begin
            // Rotate and logical modes shift out the same last bit, so the
            // carry tap is shared; only the fill differs.
            if (bus.i_subShiftDir) begin
               res_y = bus.i_useCarry ? ((bus.i_a << n) | (bus.i_a >> lidx)) : (bus.i_a << n);
               res_c = bus.i_a[lidx];
            end else begin
               res_y = bus.i_useCarry ? ((bus.i_a >> n) | (bus.i_a << lidx)) : (bus.i_a >> n);
               res_c = bus.i_a[ridx];
            end
            if (n == '0) res_c = r_carry;
         end
         default: res_v = r_ovf;
      endcase
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_start (bus.i_aluWr && is_mul && !mul_busy),
            .i_a     (bus.i_a),
            .i_b     (bus.i_b),
            .o_busy  (mul_busy),
            .o_done  (mul_done),
            .o_prod  (mul_prod)
         );
      end else begin : g_nomul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_y      <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         mul_hi_q <= 1'b0;
      end else if (mul_done) begin
         r_y   <= mul_hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
         r_ovf <= mul_hi_q ? 1'b0 : (|mul_prod[2*WIDTH-1:WIDTH]);
      end else if (bus.i_aluWr && !mul_busy) begin
         if (!is_mul || !MUL_EN) begin
            r_y     <= res_y;
            r_carry <= res_c;
            r_ovf   <= res_v;
         end else begin
            mul_hi_q <= (op == ALU_MULHI);
         end
      end
   end

   assign bus.o_negative = r_y[WIDTH-1];
   assign bus.o_nZero    = |r_y;
   assign bus.o_carry    = r_carry;
   assign bus.o_overflow = r_ovf;
   assign bus.o_busy     = mul_busy;

   generate
      for (genvar g = 0; g < WIDTH/8; g++) begin : g_tx
         alu_tx8 u_tx (
            .i_d   (r_y[8*g +: 8]),
            .i_noe (bus.i_noe),
            .o_q   (o_y[8*g +: 8])
         );
      end
   endgenerate
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench: an 8-bit multiplier-enabled ALU and a 16-bit ALU without multiplier.
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] y;
      logic        neg;
      logic        nz;
      logic        c;
      logic        v;
      logic        busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst8, rst16;
   wire  [7:0]  y8;
   wire  [15:0] y16;
   int   checks = 0;
   int   failures = 0;

   exp_t q8[$];
   exp_t q16[$];
   exp_t e8, e16;
   logic acc8 = 1'b0, rd8 = 1'b0, pb8 = 1'b0;
   logic acc16 = 1'b0, rd16 = 1'b0, pb16 = 1'b0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  if8 ();
   alu_seq_if #(.WIDTH(16)) if16 ();

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
      .i_clk(clk), .i_reset(rst8), .bus(if8), .o_y(y8)
   );
   alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
      .i_clk(clk), .i_reset(rst16), .bus(if16), .o_y(y16)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // An edge produces a result to score when it took a single-cycle write,
   // a reset, or retired a multiply (busy falling).
   always @(posedge clk) begin
      acc8  <= !rst8 && if8.i_aluWr && !if8.o_busy && (if8.i_aluOp[2:1] != 2'b10);
      rd8   <= rst8;
      acc16 <= !rst16 && if16.i_aluWr && !if16.o_busy;
      rd16  <= rst16;
   end

   always @(negedge clk) begin
      if (rd8 || acc8 || (pb8 && !if8.o_busy)) begin
         if (q8.size() == 0) begin
            failures++;
            $display("FAIL sb8_unexpected_result y=%h", y8);
         end else begin
            e8 = q8.pop_front();
            if (!if8.i_noe) chk("y8", {24'h0, y8}, e8.y);
            chk("neg8",  {31'h0, if8.o_negative}, {31'h0, e8.neg});
            chk("nz8",   {31'h0, if8.o_nZero},    {31'h0, e8.nz});
            chk("c8",    {31'h0, if8.o_carry},    {31'h0, e8.c});
            chk("v8",    {31'h0, if8.o_overflow}, {31'h0, e8.v});
            chk("busy8", {31'h0, if8.o_busy},     {31'h0, e8.busy});
         end
      end
      pb8 <= if8.o_busy;
   end

   always @(negedge clk) begin
      if (rd16 || acc16 || (pb16 && !if16.o_busy)) begin
         if (q16.size() == 0) begin
            failures++;
            $display("FAIL sb16_unexpected_result y=%h", y16);
         end else begin
            e16 = q16.pop_front();
            if (!if16.i_noe) chk("y16", {16'h0, y16}, e16.y);
            chk("neg16",  {31'h0, if16.o_negative}, {31'h0, e16.neg});
            chk("nz16",   {31'h0, if16.o_nZero},    {31'h0, e16.nz});
            chk("c16",    {31'h0, if16.o_carry},    {31'h0, e16.c});
            chk("v16",    {31'h0, if16.o_overflow}, {31'h0, e16.v});
            chk("busy16", {31'h0, if16.o_busy},     {31'h0, e16.busy});
         end
      end
      pb16 <= if16.o_busy;
   end

   task automatic push8(input logic [7:0] y, input logic c, input logic v);
      q8.push_back('{y: {24'h0, y}, neg: y[7], nz: |y, c: c, v: v, busy: 1'b0});
   endtask

   task automatic push16(input logic [15:0] y, input logic c, input logic v);
      q16.push_back('{y: {16'h0, y}, neg: y[15], nz: |y, c: c, v: v, busy: 1'b0});
   endtask

   task automatic op8(input alu_op_t op, input logic [7:0] a, b, input logic dir, uc,
                      input logic [7:0] ey, input logic ec, ev);
      if8.i_aluOp = op; if8.i_a = a; if8.i_b = b;
      if8.i_subShiftDir = dir; if8.i_useCarry = uc; if8.i_aluWr = 1'b1;
      push8(ey, ec, ev);
      @(posedge clk); #1;
      if8.i_aluWr = 1'b0;
   endtask

   task automatic op16(input alu_op_t op, input logic [15:0] a, b, input logic dir, uc,
                       input logic [15:0] ey, input logic ec, ev);
      if16.i_aluOp = op; if16.i_a = a; if16.i_b = b;
      if16.i_subShiftDir = dir; if16.i_useCarry = uc; if16.i_aluWr = 1'b1;
      push16(ey, ec, ev);
      @(posedge clk); #1;
      if16.i_aluWr = 1'b0;
   endtask

   // Starts a multiply and counts busy cycles; with poke set, an add is
   // pulsed mid-busy and the old result must still be on the bus.
   task automatic mul8(input alu_op_t op, input logic [7:0] a, b,
                       input logic [7:0] ey, input logic ec, ev,
                       input logic poke, input logic [7:0] y_old);
      int n;
      if8.i_aluOp = op; if8.i_a = a; if8.i_b = b; if8.i_aluWr = 1'b1;
      push8(ey, ec, ev);
      @(posedge clk); #1;
      if8.i_aluWr = 1'b0;
      n = 0;
      while (if8.o_busy && n < 40) begin
         if (poke && n == 2) begin
            if8.i_aluOp = ALU_ADD; if8.i_a = 8'h11; if8.i_b = 8'h22; if8.i_aluWr = 1'b1;
         end
         @(posedge clk); #1;
         n++;
         if (poke && n == 3) begin
            if8.i_aluWr = 1'b0;
            chk("mul_poke_y_held", {24'h0, y8}, {24'h0, y_old});
            chk("mul_poke_busy",   {31'h0, if8.o_busy}, 32'h1);
         end
      end
      chk("mul_busy_cycles", n, 8);
   endtask

   initial begin
      if8.i_a = '0; if8.i_b = '0; if8.i_aluOp = '0; if8.i_subShiftDir = 1'b0;
      if8.i_useCarry = 1'b0; if8.i_aluWr = 1'b0; if8.i_noe = 1'b0;
      if16.i_a = '0; if16.i_b = '0; if16.i_aluOp = '0; if16.i_subShiftDir = 1'b0;
      if16.i_useCarry = 1'b0; if16.i_aluWr = 1'b0; if16.i_noe = 1'b0;
      rst8 = 1'b1; rst16 = 1'b1;
      push8(8'h00, 1'b0, 1'b0);
      push16(16'h0000, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst8 = 1'b0; rst16 = 1'b0;

      // add / subtract / subtract-with-carry
      op8(ALU_ADD,   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8(ALU_ADD,   8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      op8(ALU_ADD,   8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      // shifts and rotates, including n=0 holding both carry values
      op8(ALU_SHIFT, 8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0);
      op8(ALU_SHIFT, 8'h81, 8'h01, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0);
      op8(ALU_SHIFT, 8'h81, 8'h03, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0);
      op8(ALU_SHIFT, 8'h81, 8'h08, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
      op8(ALU_ADD,   8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      op8(ALU_SHIFT, 8'h81, 8'h08, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
      op8(ALU_SHIFT, 8'h81, 8'h01, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
      // add with carry-in from r_carry=1, then logic ops clear ovf, hold carry
      op8(ALU_ADD,   8'h7F, 8'h01, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
      op8(ALU_AND,   8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
      op8(ALU_XOR,   8'hF0, 8'h3C, 1'b0, 1'b0, 8'hCC, 1'b0, 1'b0);
      op8(ALU_OR,    8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      op8(ALU_PASSB, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);

      // aluWr low: nothing changes even with new operands
      if8.i_aluOp = ALU_ADD; if8.i_a = 8'h33; if8.i_b = 8'h44;
      repeat (3) @(posedge clk);
      #1 chk("hold_y", {24'h0, y8}, 32'h5A);

      // multiplies
      mul8(ALU_MULHI, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h00);
      mul8(ALU_MULLO, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFE);

      // reset three cycles into a multiply aborts it
      if8.i_aluOp = ALU_MULLO; if8.i_a = 8'h33; if8.i_b = 8'h44; if8.i_aluWr = 1'b1;
      @(posedge clk); #1;
      if8.i_aluWr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst8 = 1'b1;
      push8(8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst8 = 1'b0;
      mul8(ALU_MULLO, 8'h0C, 8'h0A, 8'h78, 1'b0, 1'b0, 1'b0, 8'h00);

      // output disabled: registers and flags still update
      if8.i_noe = 1'b1;
      op8(ALU_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
      @(posedge clk); #1;
      if8.i_noe = 1'b0;
      #1 chk("noe_release_y", {24'h0, y8}, 32'h02);

      // 16-bit, no multiplier
      op16(ALU_ADD,   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16(ALU_MULLO, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      chk("nomul_busy", {31'h0, if16.o_busy}, 32'h0);
      op16(ALU_PASSB, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0);
      op16(ALU_MULHI, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0);
      op16(ALU_ADD,   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("q8_drained",  q8.size(), 0);
      chk("q16_drained", q16.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog_timeout at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 8-bit datapath ALU.
- WIDTH-bit registered-result ALU: add/sub with carry-in, AND/OR/XOR, barrel shift/rotate, and an iterative unsigned multiplier with busy handshake.
- Adds carry/overflow flags and the multi-cycle multiply. Sits between register-file buses A/B and the shared data bus.

Parameters:
- WIDTH, 8, datapath width. Must be 8, 16 or 32.
- MUL_EN, 1, 1 instantiates the multiplier; 0 makes ops 100/101 no-ops.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B; low $clog2(WIDTH) bits are the shift amount for op 011
- i_aluOp  in  3  operation: 000 add, 001 and, 010 xor, 011 shift, 100 mul-lo, 101 mul-hi, 110 or, 111 pass-B
- i_subShiftDir  in  1  add: subtract (B inverted); shift: 1 = left, 0 = right
- i_useCarry  in  1  add: cin = r_carry; shift: rotate instead of logical
- i_aluWr  in  1  capture result (single-cycle ops) or start (mul ops)
- i_noe  in  1  active-low output enable for o_y
- o_y  out  WIDTH  r_y when i_noe=0, else high-Z
- o_negative  out  1  r_y[WIDTH-1]
- o_nZero  out  1  |r_y
- o_carry  out  1  r_carry
- o_overflow  out  1  r_ovf
- o_busy  out  1  multiply in progress

Behaviour:
Clock, reset and output
- One clock, i_clk. Reset is i_reset: synchronous, active-high.
- Reset clears r_y, r_carry, r_ovf and busy to 0, so all outputs are 0 except o_y, which follows i_noe.
- Reset mid-multiply aborts the operation; no result is written.
- o_negative and o_nZero are combinational from r_y. No flag is computed from live operands.

Single-cycle ops (op ≠ 100/101, or MUL_EN=0)
- On an edge with i_aluWr=1 and busy=0: r_y and flags update from i_a/i_b. The result is visible the next cycle.
- i_aluWr=0: all registers hold.

Add (op 000)
- B' = i_b ^ {WIDTH{i_subShiftDir}}.
- cin = i_useCarry ? r_carry : i_subShiftDir.
- {carry, y} = a + B' + cin. Carry=1 on subtract means no borrow.
- ovf = (a[MSB] == B'[MSB]) && (y[MSB] != a[MSB]).

Logic ops (001, 010, 110, 111)
- Carry holds; ovf cleared.

Shift (op 011)
- n = i_b[$clog2(WIDTH)-1:0].
- Logical mode: zero fill. Carry = last bit shifted out; n=0 leaves carry unchanged.
- Rotate mode (i_useCarry=1): plain rotate, carry = bit rotated last across the boundary; n=0 leaves carry unchanged.
- ovf cleared.

Multiply (op 100/101, MUL_EN=1)
- Start: i_aluWr=1 with busy=0 captures i_a, i_b and the op at edge E0.
- o_busy=1 from after E0 through edge E0+WIDTH.
- Shift-add runs one bit per cycle for WIDTH cycles.
- At edge E0+WIDTH: r_y ← low or high half of the 2·WIDTH product, and busy drops. ovf = (high half ≠ 0) for mul-lo, 0 for mul-hi; carry holds.
- i_aluWr while busy is ignored entirely, including single-cycle ops. Operand changes during busy have no effect.
- r_y holds its old value until completion, so o_y stays drivable during busy.

Boundary cases
- Back-to-back: a new start is accepted on the same edge busy drops? No — the first edge with busy=0 is accepted.
- MUL_EN=0: ops 100/101 with i_aluWr leave all state unchanged.

Decomposition:
- Package alu_pkg:
  - typedef enum logic[2:0] alu_op_t (ALU_ADD, ALU_AND, ALU_XOR, ALU_SHIFT, ALU_MULLO, ALU_MULHI, ALU_OR, ALU_PASSB)
  - localparam function for shift-amount width.
- Sub-module alu_mul_iter(WIDTH): start/operands in; busy, done pulse and 2·WIDTH product out; synchronous reset.
- o_y drive: WIDTH/8 instances of the existing 8-bit transmitter tristate cell.

Test Plan:
- WIDTH=8, add a=0x7F b=0x01, aluWr -> y=0x80, neg=1, ovf=1, carry=0, nZero=1.
- Sub a=0x00 b=0x01 dir=1 -> y=0xFF, carry=0, neg=1. Then sbc useCarry=1 a=0x05 b=0x05 -> y=0xFF, carry=0. Then sub a=0x05 b=0x05 -> y=0x00, nZero=0, carry=1.
- Shift a=0x81 b=1 dir=0 -> y=0x40, carry=1. Rotate a=0x81 b=1 dir=0 useCarry=1 -> y=0xC0. a=0x81 b=3 dir=1 -> y=0x08, carry=0. b=8 (n=0) -> y=0x81, carry held.
- Mul-hi a=0xFF b=0xFF -> busy exactly 8 cycles, then y=0xFE. Mul-lo same operands -> y=0x01, ovf=1. aluWr add pulsed mid-busy -> ignored, y unchanged until completion.
- Reset asserted 3 cycles into a multiply -> next cycle busy=0, y=0, flags 0. A fresh mul-lo 0x0C×0x0A then yields 0x78 after 8 cycles.
- i_noe=1 -> o_y all Z while r_y and flags are unaffected. WIDTH=16, MUL_EN=0: add 0xFFFF+0x0001 -> y=0, carry=1, nZero=0. Op 100 -> no state change, busy stays 0.
